// File: rtl/evm_pkg.sv
// Shared types for the EVM multi-booth front end: session states and candidate codes.
package evm_pkg;

    typedef enum logic [1:0] {
        OFF     = 2'b00,
        OPEN    = 2'b01,
        CLOSING = 2'b10,
        DONE    = 2'b11
    } evm_state_e;

    typedef enum logic [1:0] {
        CAND_NONE = 2'b00,
        CAND_1    = 2'b01,
        CAND_2    = 2'b10,
        CAND_3    = 2'b11
    } cand_e;

    localparam int NUM_CAND = 3;

endpackage

// File: rtl/evm_rr_arbiter.sv
// Combinational one-hot booth pick; round-robin from ptr, or lowest index first
// when EVM_FIXED_PRIO_EN is defined (ptr is then ignored).
module evm_rr_arbiter #(
    parameter  int NUM_BOOTHS = 4,
    localparam int PTR_W      = $clog2(NUM_BOOTHS)
) (
    input  logic [NUM_BOOTHS-1:0] req,
    input  logic [PTR_W-1:0]      ptr,
    output logic [NUM_BOOTHS-1:0] pick,
    output logic [PTR_W-1:0]      pick_idx,
    output logic                  pick_valid
);

    always_comb begin
        pick       = '0;
        pick_idx   = '0;
        pick_valid = 1'b0;
`ifdef EVM_FIXED_PRIO_EN
        for (int i = NUM_BOOTHS - 1; i >= 0; i--) begin
            if (req[i]) begin
                pick       = '0;
                pick[i]    = 1'b1;
                pick_idx   = PTR_W'(i);
                pick_valid = 1'b1;
            end
        end
`else
        for (int off = 0; off < NUM_BOOTHS; off++) begin
            for (int i = 0; i < NUM_BOOTHS; i++) begin
                // booth i sits 'off' places after the pointer
                if (!pick_valid && req[i] && ((int'(ptr) + off) % NUM_BOOTHS) == i) begin
                    pick[i]    = 1'b1;
                    pick_idx   = PTR_W'(i);
                    pick_valid = 1'b1;
                end
            end
        end
`endif
    end

endmodule

// File: rtl/evm_booth_arbiter.sv
// Multi-booth EVM front end: session FSM, shared candidate counters, winner/result readout.
// EVM_FIXED_PRIO_EN selects fixed lowest-index booth priority instead of round-robin.
//
// state   | meaning
// OFF     | idle; requests refused; switch_on_evm opens a session (counters clear)
// OPEN    | one armed booth served per cycle
// CLOSING | single cycle; winner latched from final counts
// DONE    | results/winner readable; switch_on_evm low returns to OFF
module evm_booth_arbiter
    import evm_pkg::*;
#(
    parameter int NUM_BOOTHS = 4,
    parameter int CNT_W      = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    switch_on_evm,
    input  logic                    voting_session_done,
    input  logic [NUM_BOOTHS-1:0]   booth_req,
    input  logic [2*NUM_BOOTHS-1:0] booth_cand,
    output logic [NUM_BOOTHS-1:0]   booth_gnt,
    output logic [NUM_BOOTHS-1:0]   booth_rej,
    input  logic [1:0]              display_results,
    input  logic                    display_winner,
    output logic [CNT_W-1:0]        results,
    output logic [1:0]              candidate_name,
    output logic                    invalid_results,
    output logic                    voting_in_progress,
    output logic                    voting_done
);

    localparam int PTR_W = $clog2(NUM_BOOTHS);

    evm_state_e              state, state_nxt;
    logic [CNT_W-1:0]        cnt [NUM_CAND];
    logic [NUM_BOOTHS-1:0]   armed, req_eff, pick, gnt_nxt, rej_nxt;
    logic [PTR_W-1:0]        ptr, pick_idx;
    logic                    pick_valid;
    cand_e                   pick_cand, win_code, win_code_nxt;
    logic                    win_invalid;
    logic [CNT_W+1:0]        sum_w;
    logic [CNT_W-1:0]        total, sel_cnt;
    logic                    session_start;

    assign req_eff       = booth_req & armed;
    assign session_start = (state == OFF) && switch_on_evm;

    evm_rr_arbiter #(.NUM_BOOTHS(NUM_BOOTHS)) u_arb (
        .req        (req_eff),
        .ptr        (ptr),
        .pick       (pick),
        .pick_idx   (pick_idx),
        .pick_valid (pick_valid)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            OFF:     if (switch_on_evm)       state_nxt = OPEN;
            OPEN:    if (voting_session_done) state_nxt = CLOSING;
            CLOSING:                          state_nxt = DONE;
            DONE:    if (!switch_on_evm)      state_nxt = OFF;
            default:                          state_nxt = OFF;
        endcase
    end

    always_comb begin
        pick_cand = CAND_NONE;
        for (int i = 0; i < NUM_BOOTHS; i++) begin
            if (pick[i]) pick_cand = cand_e'(booth_cand[2*i +: 2]);
        end
    end

    // Outside OPEN every armed requester is refused at once, multi-hot.
    always_comb begin
        gnt_nxt = '0;
        rej_nxt = '0;
        if (state == OPEN) begin
            if (pick_valid) begin
                if (pick_cand == CAND_NONE) rej_nxt = pick;
                else                        gnt_nxt = pick;
            end
        end else begin
            rej_nxt = req_eff;
        end
    end

    always_comb begin
        sum_w = {2'b00, cnt[0]} + {2'b00, cnt[1]} + {2'b00, cnt[2]};
        total = (|sum_w[CNT_W+1:CNT_W]) ? '1 : sum_w[CNT_W-1:0];
        case (display_results)
            2'b00:   sel_cnt = total;
            2'b01:   sel_cnt = cnt[0];
            2'b10:   sel_cnt = cnt[1];
            default: sel_cnt = cnt[2];
        endcase
    end

    always_comb begin
        win_code_nxt = CAND_NONE;
        if      (cnt[0] > cnt[1] && cnt[0] > cnt[2]) win_code_nxt = CAND_1;
        else if (cnt[1] > cnt[0] && cnt[1] > cnt[2]) win_code_nxt = CAND_2;
        else if (cnt[2] > cnt[0] && cnt[2] > cnt[1]) win_code_nxt = CAND_3;
    end

`ifdef EVM_FIXED_PRIO_EN
    assign ptr = '0;
`else
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (state == OPEN && pick_valid) begin
            ptr <= (pick_idx == PTR_W'(NUM_BOOTHS - 1)) ? '0 : pick_idx + PTR_W'(1);
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state              <= OFF;
            for (int c = 0; c < NUM_CAND; c++) cnt[c] <= '0;
            armed              <= '1;
            booth_gnt          <= '0;
            booth_rej          <= '0;
            win_code           <= CAND_NONE;
            win_invalid        <= 1'b0;
            results            <= '0;
            candidate_name     <= CAND_NONE;
            invalid_results    <= 1'b0;
            voting_in_progress <= 1'b0;
            voting_done        <= 1'b0;
        end else begin
            state     <= state_nxt;
            // re-arm only once the booth has let its request go
            armed     <= (armed & ~(gnt_nxt | rej_nxt)) | ~booth_req;
            booth_gnt <= gnt_nxt;
            booth_rej <= rej_nxt;
            for (int c = 0; c < NUM_CAND; c++) begin
                if (session_start) begin
                    cnt[c] <= '0;
                end else if ((|gnt_nxt) && int'(pick_cand) == c + 1 && cnt[c] != '1) begin
                    cnt[c] <= cnt[c] + CNT_W'(1);
                end
            end
            if (state == CLOSING) begin
                win_code    <= win_code_nxt;
                win_invalid <= (win_code_nxt == CAND_NONE);
            end
            results            <= (state == DONE) ? sel_cnt : '0;
            candidate_name     <= (state == DONE && display_winner) ? win_code : CAND_NONE;
            invalid_results    <= (state == DONE) && display_winner && win_invalid;
            voting_in_progress <= (state_nxt == OPEN);
            voting_done        <= (state_nxt == DONE);
        end
    end

endmodule

// File: tb/tb_evm_booth_arbiter.sv
// Directed bench for evm_booth_arbiter: per-cycle vector table plus reset and saturation sequences.
module tb_evm_booth_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       sw, sd, dw;
    logic [3:0] req;
    logic [7:0] cand;
    logic [1:0] dr;
    logic [3:0] gnt, rej;
    logic [7:0] res;
    logic [1:0] name;
    logic       inv, vip, vd;

    logic       sw_s, sd_s, dw_s;
    logic [3:0] req_s;
    logic [7:0] cand_s;
    logic [1:0] dr_s;
    logic [3:0] gnt_s, rej_s;
    logic [1:0] res_s;
    logic [1:0] name_s;
    logic       inv_s, vip_s, vd_s;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    evm_booth_arbiter #(.NUM_BOOTHS(4), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .switch_on_evm(sw), .voting_session_done(sd),
        .booth_req(req), .booth_cand(cand), .booth_gnt(gnt), .booth_rej(rej),
        .display_results(dr), .display_winner(dw), .results(res),
        .candidate_name(name), .invalid_results(inv),
        .voting_in_progress(vip), .voting_done(vd)
    );

    evm_booth_arbiter #(.NUM_BOOTHS(4), .CNT_W(2)) dut_s (
        .clk(clk), .rst(rst), .switch_on_evm(sw_s), .voting_session_done(sd_s),
        .booth_req(req_s), .booth_cand(cand_s), .booth_gnt(gnt_s), .booth_rej(rej_s),
        .display_results(dr_s), .display_winner(dw_s), .results(res_s),
        .candidate_name(name_s), .invalid_results(inv_s),
        .voting_in_progress(vip_s), .voting_done(vd_s)
    );

    typedef struct {
        logic       sw, sd;
        logic [3:0] req;
        logic [7:0] cand;
        logic [1:0] dr;
        logic       dw;
        logic [3:0] gnt, rej;
        logic [7:0] res;
        logic [1:0] name;
        logic       inv, vip, vd;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic a_sw, input logic a_sd, input logic [3:0] a_req,
                       input logic [7:0] a_cand, input logic [1:0] a_dr, input logic a_dw,
                       input logic [3:0] e_gnt, input logic [3:0] e_rej, input logic [7:0] e_res,
                       input logic [1:0] e_name, input logic e_inv, input logic e_vip,
                       input logic e_vd);
        vec_t v;
        v.sw = a_sw; v.sd = a_sd; v.req = a_req; v.cand = a_cand; v.dr = a_dr; v.dw = a_dw;
        v.gnt = e_gnt; v.rej = e_rej; v.res = e_res; v.name = e_name; v.inv = e_inv;
        v.vip = e_vip; v.vd = e_vd;
        vecs.push_back(v);
    endtask

    task automatic chk(input string what, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", what, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // sw sd req cand dr dw | gnt rej res name inv vip vd
        add(0,0,4'b0100,8'h10,0,0, 4'b0000,4'b0100,0,0,0,0,0);  // request in OFF refused
        add(1,0,4'b0000,8'h00,0,0, 4'b0000,4'b0000,0,0,0,1,0);  // open
        add(1,0,4'b0001,8'h01,0,0, 4'b0001,4'b0000,0,0,0,1,0);  // booth0 -> cand1
        add(1,0,4'b0000,8'h00,0,0, 4'b0000,4'b0000,0,0,0,1,0);
        add(1,0,4'b0100,8'h30,0,0, 4'b0100,4'b0000,0,0,0,1,0);  // booth2 -> cand3
        add(1,0,4'b0000,8'h00,0,0, 4'b0000,4'b0000,0,0,0,1,0);
        add(0,0,4'b0000,8'h00,0,0, 4'b0000,4'b0000,0,0,0,1,0);  // switch off ignored in OPEN
        add(1,1,4'b0000,8'h00,0,0, 4'b0000,4'b0000,0,0,0,0,0);  // close
        add(1,0,4'b0000,8'h00,0,0, 4'b0000,4'b0000,0,0,0,0,1);  // DONE
        add(1,0,4'b0000,8'h00,0,1, 4'b0000,4'b0000,2,0,1,0,1);  // total 2, tie -> invalid
        add(1,0,4'b0000,8'h00,1,0, 4'b0000,4'b0000,1,0,0,0,1);
        add(1,0,4'b0000,8'h00,2,0, 4'b0000,4'b0000,0,0,0,0,1);
        add(1,0,4'b0000,8'h00,3,0, 4'b0000,4'b0000,1,0,0,0,1);
        add(1,0,4'b1000,8'h80,3,0, 4'b0000,4'b1000,1,0,0,0,1);  // request in DONE refused
        add(0,0,4'b0000,8'h00,3,0, 4'b0000,4'b0000,1,0,0,0,0);  // back to OFF
        add(0,0,4'b0000,8'h00,3,0, 4'b0000,4'b0000,0,0,0,0,0);
        add(1,0,4'b0000,8'h00,0,0, 4'b0000,4'b0000,0,0,0,1,0);  // session 2
        add(1,0,4'b1000,8'h00,0,0, 4'b0000,4'b1000,0,0,0,1,0);  // code 00 -> reject, ptr wraps to 0
        add(1,0,4'b0000,8'h00,0,0, 4'b0000,4'b0000,0,0,0,1,0);
        add(1,0,4'b1111,8'hAA,0,0, 4'b0001,4'b0000,0,0,0,1,0);  // all four vote cand2
        add(1,0,4'b1111,8'hAA,0,0, 4'b0010,4'b0000,0,0,0,1,0);
        add(1,0,4'b1111,8'hAA,0,0, 4'b0100,4'b0000,0,0,0,1,0);
        add(1,0,4'b1111,8'hAA,0,0, 4'b1000,4'b0000,0,0,0,1,0);
        add(1,0,4'b1111,8'hAA,0,0, 4'b0000,4'b0000,0,0,0,1,0);  // held requests not re-served
        add(1,0,4'b0000,8'h00,0,0, 4'b0000,4'b0000,0,0,0,1,0);
        add(1,0,4'b0010,8'h08,0,0, 4'b0010,4'b0000,0,0,0,1,0);  // booth1 holds after grant
        add(1,0,4'b0010,8'h08,0,0, 4'b0000,4'b0000,0,0,0,1,0);
        add(1,0,4'b0010,8'h08,0,0, 4'b0000,4'b0000,0,0,0,1,0);
        add(1,0,4'b0010,8'h08,0,0, 4'b0000,4'b0000,0,0,0,1,0);
        add(1,0,4'b0000,8'h00,0,0, 4'b0000,4'b0000,0,0,0,1,0);
        add(1,0,4'b0010,8'h08,0,0, 4'b0010,4'b0000,0,0,0,1,0);  // re-asserted -> second grant
        add(1,0,4'b0000,8'h00,0,0, 4'b0000,4'b0000,0,0,0,1,0);
        add(1,1,4'b0001,8'h02,0,0, 4'b0001,4'b0000,0,0,0,0,0);  // vote and close same cycle
        add(1,0,4'b0000,8'h00,0,0, 4'b0000,4'b0000,0,0,0,0,1);
        add(1,0,4'b0000,8'h00,2,1, 4'b0000,4'b0000,7,2,0,0,1);  // cand2 = 7, winner cand2
        add(1,0,4'b0000,8'h00,0,1, 4'b0000,4'b0000,7,2,0,0,1);
        add(1,0,4'b0000,8'h00,1,0, 4'b0000,4'b0000,0,0,0,0,1);
        add(0,0,4'b0000,8'h00,1,0, 4'b0000,4'b0000,0,0,0,0,0);
        add(1,0,4'b0000,8'h00,0,0, 4'b0000,4'b0000,0,0,0,1,0);  // session 3, ptr at booth1
        add(1,0,4'b0101,8'h11,0,0, 4'b0100,4'b0000,0,0,0,1,0);  // rr picks booth2 first
        add(1,0,4'b0101,8'h11,0,0, 4'b0001,4'b0000,0,0,0,1,0);
        add(1,1,4'b0000,8'h00,0,0, 4'b0000,4'b0000,0,0,0,0,0);
        add(1,0,4'b0000,8'h00,0,0, 4'b0000,4'b0000,0,0,0,0,1);
        add(1,0,4'b0000,8'h00,1,1, 4'b0000,4'b0000,2,1,0,0,1);  // strict winner cand1

        sw = 0; sd = 0; req = '0; cand = '0; dr = '0; dw = 0;
        sw_s = 0; sd_s = 0; req_s = '0; cand_s = '0; dr_s = '0; dw_s = 0;
        rst = 1'b1;
        step(); step();
        chk("reset gnt", 32'(gnt), 0);
        chk("reset rej", 32'(rej), 0);
        chk("reset results", 32'(res), 0);
        chk("reset name", 32'(name), 0);
        chk("reset invalid", 32'(inv), 0);
        chk("reset in_progress", 32'(vip), 0);
        chk("reset done", 32'(vd), 0);
        chk("reset small results", 32'(res_s), 0);
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) begin
            sw = vecs[i].sw; sd = vecs[i].sd; req = vecs[i].req; cand = vecs[i].cand;
            dr = vecs[i].dr; dw = vecs[i].dw;
            step();
            chk($sformatf("row%0d gnt", i), 32'(gnt), 32'(vecs[i].gnt));
            chk($sformatf("row%0d rej", i), 32'(rej), 32'(vecs[i].rej));
            chk($sformatf("row%0d results", i), 32'(res), 32'(vecs[i].res));
            chk($sformatf("row%0d name", i), 32'(name), 32'(vecs[i].name));
            chk($sformatf("row%0d invalid", i), 32'(inv), 32'(vecs[i].inv));
            chk($sformatf("row%0d in_progress", i), 32'(vip), 32'(vecs[i].vip));
            chk($sformatf("row%0d done", i), 32'(vd), 32'(vecs[i].vd));
        end

        // reset in the middle of an open session
        sw = 0; sd = 0; req = '0; cand = '0;
        step();
        sw = 1;
        step();
        chk("midrst open", 32'(vip), 1);
        req = 4'b0010; cand = 8'h0C;
        step();
        chk("midrst vote gnt", 32'(gnt), 32'(4'b0010));
        req = '0;
        #2 rst = 1'b1;
        #1;
        chk("midrst gnt", 32'(gnt), 0);
        chk("midrst in_progress", 32'(vip), 0);
        chk("midrst results", 32'(res), 0);
        chk("midrst done", 32'(vd), 0);
        @(negedge clk);
        rst = 1'b0; sw = 0;
        step();
        chk("post rst off", 32'(vip), 0);
        sw = 1;
        step();
        chk("post rst open", 32'(vip), 1);
        sd = 1;
        step();
        sd = 0;
        step();
        chk("post rst done", 32'(vd), 1);
        dr = 2'b00; dw = 1;
        step();
        chk("zero votes total", 32'(res), 0);
        chk("zero votes name", 32'(name), 0);
        chk("zero votes invalid", 32'(inv), 1);
        sw = 0; dw = 0;
        step();

        // 2-bit counters saturate
        sw_s = 1;
        step();
        chk("sat open", 32'(vip_s), 1);
        for (int v = 0; v < 5; v++) begin
            req_s = 4'b0001; cand_s = 8'h01;
            step();
            chk($sformatf("sat vote%0d gnt", v), 32'(gnt_s), 32'(4'b0001));
            req_s = '0;
            step();
        end
        req_s = 4'b0010; cand_s = 8'h08;
        step();
        chk("sat cand2 gnt", 32'(gnt_s), 32'(4'b0010));
        req_s = '0;
        step();
        sd_s = 1;
        step();
        sd_s = 0;
        step();
        dr_s = 2'b01;
        step();
        chk("sat cand1 count", 32'(res_s), 3);
        dr_s = 2'b00;
        step();
        chk("sat total", 32'(res_s), 3);
        dr_s = 2'b10;
        step();
        chk("sat cand2 count", 32'(res_s), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/evm_booth_arbiter.md
# evm_booth_arbiter

Multi-booth front end for the EVM tally datapath. It arbitrates up to NUM_BOOTHS voting booths onto one shared set of three candidate counters. It sequences the voting session (off / open / closing / done) and serves result and winner readout. It sits between the booth panels and the display logic, and drives the same session status signals (voting_in_progress, voting_done, results, candidate_name, invalid_results) the rest of the EVM consumes.

## Interface
- NUM_BOOTHS, 4: number of requesting booths (2..8)
- CNT_W, 8: width of each candidate counter and of results
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- switch_on_evm  in  1  level; opens a session from OFF, returns to OFF from DONE when low
- voting_session_done  in  1  level; closes an open session
- booth_req  in  NUM_BOOTHS  per-booth vote request, level, held until booth_gnt or booth_rej
- booth_cand  in  2*NUM_BOOTHS  per-booth candidate code: 01/10/11 = candidate 1/2/3, 00 = invalid
- booth_gnt  out  NUM_BOOTHS  one-hot, one-cycle pulse: vote counted
- booth_rej  out  NUM_BOOTHS  one-cycle pulse per booth: vote refused
- display_results  in  2  00 = total votes, 01/10/11 = candidate 1/2/3 count
- display_winner  in  1  enables winner outputs
- results  out  CNT_W  selected count, registered
- candidate_name  out  2  winning candidate code, registered
- invalid_results  out  1  tie for maximum or zero votes, registered
- voting_in_progress  out  1  state == OPEN
- voting_done  out  1  state == DONE

## Operation
- FSM states: OFF, OPEN, CLOSING, DONE.
  - OFF -> OPEN on switch_on_evm=1. All counters clear on this transition.
  - OPEN -> CLOSING on voting_session_done=1.
  - CLOSING -> DONE unconditionally; CLOSING lasts one cycle and computes the winner.
  - DONE -> OFF on switch_on_evm=0.
  - switch_on_evm=0 while in OPEN is ignored.
- Per-booth armed flag, reset to 1.
  - Cleared when the booth receives gnt or rej.
  - Set again only after that booth's booth_req is sampled low. This gives one vote per request assertion.
- In OPEN, each cycle one armed requesting booth wins round-robin. Search starts at the booth after the last winner.
  - Winner with valid code: booth_gnt, and the candidate counter increments.
  - Winner with code 00: booth_rej, no count.
  - Losers keep waiting; they get no pulse.
- In OFF, CLOSING, DONE: every armed requesting booth gets booth_rej in the same cycle (multi-hot allowed) and disarms.
- Counters saturate at all-ones. A vote at saturation still gets booth_gnt; the count holds.
- Total = sum of the three counts, saturating at all-ones in CNT_W.
- Winner = candidate with the strictly greatest count.
  - Tie for the maximum, or all counts zero: invalid_results=1 and candidate_name=00.
- results shows the selected count only in DONE, else 0.
- candidate_name and invalid_results are nonzero only when in DONE and display_winner=1.

## Timing
- Reset values:
  - State OFF; counters 0; round-robin pointer at booth 0; all armed.
  - booth_gnt=0, booth_rej=0, results=0, candidate_name=00, invalid_results=0, voting_in_progress=0, voting_done=0.
- booth_req sampled at edge k -> booth_gnt/booth_rej high for the cycle after edge k; the counter updates at edge k.
- results, candidate_name, invalid_results follow their select inputs with one cycle of latency.
- voting_in_progress and voting_done are registered and change on the edge of the state change.
- voting_session_done and a request in the same OPEN cycle: that cycle's arbitration is honored and counted before CLOSING.
- Reset asserted mid-session: immediate return to reset values; all votes are lost.

## Configuration
- EVM_FIXED_PRIO_EN defined: fixed priority, lowest booth index wins; the pointer logic is removed.
- Not defined: round-robin as described above.

## Structure
- Package evm_pkg contains:
  - state enum evm_state_e {OFF, OPEN, CLOSING, DONE};
  - candidate code typedef cand_e {CAND_NONE=2'b00, CAND_1, CAND_2, CAND_3};
  - constant NUM_CAND=3.
- Sub-module evm_rr_arbiter: combinational one-hot pick from (req & armed) and the pointer; the pointer register stays in the top. Its fixed-priority variant is selected by EVM_FIXED_PRIO_EN.
- Counters, winner compare and FSM live in the top.

## Test plan
- Open session, booth 0 votes 01, booth 2 votes 11 in separate cycles, close, display_results=00 -> results=2; display_winner=1 -> invalid_results=1 (tie 1/0/1), candidate_name=00.
- All 4 booths request 10 in the same cycle, pointer at 0 -> grants on booths 0,1,2,3 in four consecutive cycles; candidate 2 count=4.
- Booth 1 holds booth_req high for 5 cycles after its grant -> exactly one booth_gnt and count=1; after the request drops and rises again -> second grant.
- Booth 3 requests with code 00 -> booth_rej for one cycle, all counts unchanged.
- Request in OFF or DONE -> booth_rej, no count; voting_session_done in the same cycle as a valid request in OPEN -> vote counted, voting_done=1 two cycles later.
- CNT_W=2, five votes for candidate 1 -> five grants, results=3 (saturated); rst mid-OPEN -> all outputs 0, state OFF.
